// File: rtl/noc_packet_receiver_if.sv
// Flit-in / payload-out stream bundle for the NoC receive interface.
// slave = receiver view, master = router + local consumer view.
interface noc_packet_receiver_if #(
  parameter int DATA_W = 32,
  parameter int X_W    = 4,
  parameter int Y_W    = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_flit;
  logic              in_is_header;
  logic              in_is_tail;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [X_W-1:0]    out_src_x;
  logic [Y_W-1:0]    out_src_y;

  modport slave (
    input  in_valid, in_flit, in_is_header, in_is_tail, out_ready,
    output in_ready, out_valid, out_data, out_last, out_src_x, out_src_y
  );

  modport master (
    output in_valid, in_flit, in_is_header, in_is_tail, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_src_x, out_src_y
  );
endinterface

// File: rtl/noc_packet_receiver.sv
// NoC receive NI: checks header/tail, strips them, queues payload tagged with source ID.
// Optional NOC_RX_ERR_CNT_EN adds a saturating 16-bit error counter with clear.
module noc_packet_receiver #(
  parameter int                X_W    = 4,
  parameter int                Y_W    = 4,
  parameter logic [X_W-1:0]    X_ID   = '0,
  parameter logic [Y_W-1:0]    Y_ID   = '0,
  parameter int                DATA_W = 32,
  parameter int                LEN_W  = 8,
  parameter int                DEPTH  = 4
) (
  input  logic        noc_clk,
  input  logic        noc_rst,
  noc_packet_receiver_if.slave bus,
  output logic        pkt_done,
  output logic        pkt_err
`ifdef NOC_RX_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt,
  input  logic        err_cnt_clr
`endif
);
  localparam int AW     = $clog2(DEPTH);
  localparam int SX_HI  = DATA_W - 5;
  localparam int SY_HI  = SX_HI - X_W;
  localparam int DX_HI  = SY_HI - Y_W;
  localparam int DY_HI  = DX_HI - X_W;
  localparam int LEN_HI = DY_HI - Y_W;

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DROP} state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [X_W-1:0]   cur_sx;
  logic [Y_W-1:0]   cur_sy;

  // header field slices
  logic [3:0]       marker;
  logic [X_W-1:0]   f_sx, f_dx;
  logic [Y_W-1:0]   f_sy, f_dy;
  logic [LEN_W-1:0] f_len;
  assign marker = bus.in_flit[DATA_W-1 -: 4];
  assign f_sx   = bus.in_flit[SX_HI -: X_W];
  assign f_sy   = bus.in_flit[SY_HI -: Y_W];
  assign f_dx   = bus.in_flit[DX_HI -: X_W];
  assign f_dy   = bus.in_flit[DY_HI -: Y_W];
  assign f_len  = bus.in_flit[LEN_HI -: LEN_W];

  logic unused_lsbs;
  assign unused_lsbs = ^bus.in_flit[LEN_HI-LEN_W:0];

  // FIFO: extra pointer bit distinguishes full from empty
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_last [DEPTH];
  logic [X_W-1:0]    mem_sx   [DEPTH];
  logic [Y_W-1:0]    mem_sy   [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, push, pop, acc;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign bus.in_ready = (state != DATA) || !full;
  assign acc  = bus.in_valid && bus.in_ready;
  assign push = acc && (state == DATA);
  assign pop  = !empty && bus.out_ready;

  // Head is masked while empty so outputs read zero after reset.
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
  assign bus.out_last  = empty ? 1'b0 : mem_last[rd_ptr[AW-1:0]];
  assign bus.out_src_x = empty ? '0 : mem_sx[rd_ptr[AW-1:0]];
  assign bus.out_src_y = empty ? '0 : mem_sy[rd_ptr[AW-1:0]];

  logic hdr_ok, dst_hit, tail_ok, err_evt, done_evt;
  assign hdr_ok  = bus.in_is_header && (marker == 4'hA) && (f_len != '0);
  assign dst_hit = (f_dx == X_ID) && (f_dy == Y_ID);
  assign tail_ok = bus.in_is_tail && (marker == 4'h5);

  always_comb begin
    err_evt  = 1'b0;
    done_evt = 1'b0;
    if (acc) begin
      case (state)
        IDLE:    err_evt  = !(hdr_ok && dst_hit);
        TAIL: begin
          done_evt = tail_ok;
          err_evt  = !tail_ok;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state    <= IDLE;
      rem      <= '0;
      cur_sx   <= '0;
      cur_sy   <= '0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
    end else begin
      pkt_done <= done_evt;
      pkt_err  <= err_evt;
      if (acc) begin
        case (state)
          IDLE: if (hdr_ok && dst_hit) begin
            cur_sx <= f_sx;
            cur_sy <= f_sy;
            rem    <= f_len;
            state  <= DATA;
          end else if (hdr_ok) begin
            state  <= DROP;
          end
          DATA: begin
            rem <= rem - 1'b1;
            if (rem == LEN_W'(1)) state <= TAIL;
          end
          TAIL: state <= IDLE;
          DROP: if (bus.in_is_tail) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge noc_clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= bus.in_flit;
      mem_last[wr_ptr[AW-1:0]] <= (rem == LEN_W'(1));
      mem_sx[wr_ptr[AW-1:0]]   <= cur_sx;
      mem_sy[wr_ptr[AW-1:0]]   <= cur_sy;
    end
  end

`ifdef NOC_RX_ERR_CNT_EN
  // Counts in step with the pkt_err register so a same-cycle clear wins.
  always_ff @(posedge noc_clk) begin
    if (noc_rst || err_cnt_clr)           err_cnt <= '0;
    else if (err_evt && err_cnt != '1)    err_cnt <= err_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_noc_packet_receiver.sv
// Directed bench for noc_packet_receiver: stimulus pushes expected beats, a monitor pops/compares.
module tb_noc_packet_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pkt_done, pkt_err;
  always #5 clk = ~clk;

  noc_packet_receiver_if #(.DATA_W(32), .X_W(4), .Y_W(4)) bus ();

`ifdef NOC_RX_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic        err_cnt_clr = 1'b0;
`endif

  noc_packet_receiver #(
    .X_W(4), .Y_W(4), .X_ID(4'd1), .Y_ID(4'd2),
    .DATA_W(32), .LEN_W(8), .DEPTH(4)
  ) dut (
    .noc_clk  (clk),
    .noc_rst  (rst),
    .bus      (bus.slave),
    .pkt_done (pkt_done),
    .pkt_err  (pkt_err)
`ifdef NOC_RX_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt),
    .err_cnt_clr (err_cnt_clr)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  sx;
    logic [3:0]  sy;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0, fails = 0;
  int   done_seen = 0, err_seen = 0;
  int   exp_done = 0, exp_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pulse counting and scoreboard pops on every out handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_done) done_seen++;
      if (pkt_err)  err_seen++;
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) chk("spurious_out", {32'h0, bus.out_data}, 64'hDEAD);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_beat", {23'h0, bus.out_data, bus.out_last, bus.out_src_x, bus.out_src_y},
              {23'h0, e});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] f, input logic h, input logic t);
    int w;
    bus.in_valid = 1'b1; bus.in_flit = f; bus.in_is_header = h; bus.in_is_tail = t;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.in_is_header = 1'b0; bus.in_is_tail = 1'b0;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic l, input logic [3:0] x, input logic [3:0] y);
    sbq.push_back({d, l, x, y});
  endtask

  task automatic check_counts(input string tag);
    idle(6);
    chk({tag, "_done"}, 64'(done_seen), 64'(exp_done));
    chk({tag, "_err"},  64'(err_seen),  64'(exp_err));
    chk({tag, "_drain"}, 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.in_flit = '0; bus.in_is_header = 0; bus.in_is_tail = 0;
    bus.out_ready = 0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_out_meta",  64'({bus.out_last, bus.out_src_x, bus.out_src_y}), 64'd0);
    chk("rst_pulses",    64'({pkt_done, pkt_err}), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    idle(1);

    // basic packet, src (3,0), len 2
    bus.out_ready = 1;
    expect_beat(32'h1111_1111, 0, 4'd3, 4'd0);
    expect_beat(32'h2222_2222, 1, 4'd3, 4'd0);
    send(32'hA301_2020, 1, 0);
    send(32'h1111_1111, 0, 0);
    send(32'h2222_2222, 0, 0);
    send(32'h5000_0000, 0, 1);
    exp_done++;
    check_counts("basic");

    // backpressure: len 6 into depth-4 FIFO
    bus.out_ready = 0;
    send(32'hA301_2060, 1, 0);
    for (int i = 1; i <= 6; i++) expect_beat(32'h0A00_0000 + 32'(i), (i == 6), 4'd3, 4'd0);
    for (int i = 1; i <= 4; i++) send(32'h0A00_0000 + 32'(i), 0, 0);
    @(negedge clk);
    chk("full_in_ready",  64'(bus.in_ready),  64'd0);
    chk("stall_valid",    64'(bus.out_valid), 64'd1);
    chk("stall_head",     64'(bus.out_data),  64'h0A00_0001);
    idle(1);
    bus.out_ready = 1;
    send(32'h0A00_0005, 0, 0);
    send(32'h0A00_0006, 0, 0);
    send(32'h5ABC_0000, 0, 1);
    exp_done++;
    check_counts("bp");

    // foreign destination (0,0), len 3: dropped
    send(32'hA300_0030, 1, 0);
    send(32'h1234_5678, 0, 0);
    send(32'h5000_0000, 0, 0);
    send(32'hA301_2020, 1, 0);
    send(32'h5000_0000, 0, 1);
    exp_err++;
    @(negedge clk);
    chk("drop_no_out", 64'(bus.out_valid), 64'd0);
    idle(1);
    expect_beat(32'h3333_3333, 0, 4'd2, 4'd9);
    expect_beat(32'h4444_4444, 1, 4'd2, 4'd9);
    send(32'hA291_2020, 1, 0);
    send(32'h3333_3333, 0, 0);
    send(32'h4444_4444, 0, 0);
    send(32'h5FFF_FFFF, 0, 1);
    exp_done++;
    check_counts("drop");

    // stray data flit in IDLE, then packet with bad tail marker
    send(32'hA301_2020, 0, 0);
    exp_err++;
    expect_beat(32'h7777_7777, 1, 4'd5, 4'd7);
    send(32'hA571_2010, 1, 0);
    send(32'h7777_7777, 0, 0);
    send(32'h3000_0000, 0, 1);
    exp_err++;
    check_counts("badtail");

`ifdef NOC_RX_ERR_CNT_EN
    chk("err_cnt_3", 64'(err_cnt), 64'd3);
    err_cnt_clr = 1'b1;
    send(32'h0000_0000, 0, 0);
    err_cnt_clr = 1'b0;
    exp_err++;
    idle(2);
    chk("err_cnt_clr", 64'(err_cnt), 64'd0);
`endif

    // reset mid-packet with one buffered data flit
    bus.out_ready = 0;
    send(32'hA301_2020, 1, 0);
    send(32'hBAD0_BAD0, 0, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid",    64'(bus.out_valid), 64'd0);
    chk("midrst_data",     64'(bus.out_data),  64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready),  64'd1);
    idle(1);
    bus.out_ready = 1;
    expect_beat(32'h5555_5555, 1, 4'd3, 4'd0);
    send(32'hA301_2010, 1, 0);
    send(32'h5555_5555, 0, 0);
    send(32'h5000_0000, 0, 1);
    exp_done++;
    check_counts("afterrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/noc_packet_receiver.md
# noc_packet_receiver

Receive-side network interface for a NoC node. Accepts header/data/tail flits from the router's local output port, checks markers and destination ID, and strips header and tail. Buffers payload flits in a small FIFO and presents them to the local consumer as a valid/ready stream tagged with the source node ID. It is the counterpart of the node-side packet sender.

## Interface
- X_ID, 0: this node's X coordinate (X_W bits)
- Y_ID, 0: this node's Y coordinate (Y_W bits)
- DATA_W, 32: flit width
- X_W, 4: X ID width
- Y_W, 4: Y ID width
- LEN_W, 8: payload length field width
- DEPTH, 4: payload FIFO depth; power of two, ≥2
- noc_clk  in  1  clock
- noc_rst  in  1  reset. Synchronous and active-high; one clock; reset is synchronous and active-high.
- in_valid  in  1  flit valid from router
- in_ready  out  1  flit accepted when in_valid & in_ready
- in_flit  in  DATA_W  flit
- in_is_header  in  1  sideband header flag
- in_is_tail  in  1  sideband tail flag
- out_valid  out  1  payload flit available
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W  payload flit
- out_last  out  1  last payload flit of the packet
- out_src_x  out  X_W  source X of the packet
- out_src_y  out  Y_W  source Y of the packet
- pkt_done  out  1  one-cycle pulse when a good tail is accepted
- pkt_err  out  1  one-cycle pulse on any protocol error

## Operation
- Header flit, MSB first:
  - [DATA_W-1:DATA_W-4] = 4'hA
  - then src_x, src_y, dst_x, dst_y
  - then len (LEN_W bits, number of data flits)
  - remaining LSBs are don't-care
- Tail flit: [DATA_W-1:DATA_W-4] = 4'h5; rest don't-care. Data flits are raw.
- FSM states IDLE, DATA, TAIL, DROP; reset to IDLE.
- IDLE: waits for an accepted flit.
  - Header is valid when in_is_header=1, marker 4'hA and len≠0.
  - Valid header with dst==(X_ID,Y_ID): latch src_x/src_y and len into the remaining counter, go to DATA.
  - Valid header with another dst: pkt_err, go to DROP.
  - Any other flit in IDLE: pkt_err, flit discarded, stay IDLE.
- DATA: each accepted flit is written to the FIFO with last=(remaining==1). Remaining decrements; at 1 go to TAIL. Markers and sideband flags are not checked in DATA.
- TAIL: the accepted flit must have in_is_tail=1 and marker 4'h5.
  - Good tail: pkt_done pulse.
  - Bad tail: pkt_err pulse; the flit is consumed either way.
  - Next state IDLE.
- DROP: consumes flits with no FIFO write until an accepted flit with in_is_tail=1, then IDLE. No further pkt_err while in DROP.
- out_src_x/out_src_y are stored per FIFO entry, so they stay correct when packets from different sources are queued back to back.

## Timing
- in_ready = 1 in IDLE, TAIL and DROP; in DATA it is !fifo_full. Combinational from state and FIFO count only, never from in_valid.
- Latency: a data flit accepted in cycle N drives out_valid in cycle N+1 if the FIFO was empty.
- out_valid = FIFO non-empty. out_* are driven from the FIFO head.
- Out-side handshake:
  - out_data, out_last and src fields stay stable while out_valid & !out_ready.
  - A pop occurs on out_valid & out_ready.
- Simultaneous push and pop when full: push is blocked, because in_ready was 0. When empty, push and pop in the same cycle is impossible, since out_valid=0.
- Full throughput: one flit per cycle in and out when out_ready=1.
- pkt_done and pkt_err are registered and asserted in the cycle after the triggering accept.
- Reset at any point returns the block to:
  - FSM IDLE; FIFO emptied (pointers 0)
  - out_valid=0, out_data=0, out_last=0, out_src_x=0, out_src_y=0
  - pkt_done=0, pkt_err=0
  - in_ready=1 in the first cycle after reset
- Partial packets are lost on reset.

## Configuration
- NOC_RX_ERR_CNT_EN defined:
  - Adds output err_cnt (16 bits). It increments on each pkt_err pulse, saturates at 16'hFFFF and resets to 0.
  - Adds input err_cnt_clr (1 bit); when asserted it clears the counter, with priority over increment.
- NOC_RX_ERR_CNT_EN undefined: no counter and no extra ports. pkt_err behaviour is identical in both builds.

## Test plan
- X_ID=1, Y_ID=2. Header (src 3,0, dst 1,2, len 2), data 32'h1111_1111, data 32'h2222_2222, tail, with out_ready=1 → outputs 1111_1111 (last=0) then 2222_2222 (last=1), src=(3,0), one pkt_done, no pkt_err.
- Same packet with out_ready=0 and DEPTH=4, len=6 → in_ready drops after 4 data flits. Raise out_ready → all 6 flits delivered in order, last on the 6th.
- Header with dst (0,0) and len 3, then 3 data flits and a tail → one pkt_err, no out_valid, FSM back in IDLE, next good packet delivered.
- Data flit in IDLE (in_is_header=0) → pkt_err pulse, flit discarded. Tail flit carrying marker 4'h3 → pkt_err, no pkt_done, packet data still delivered.
- Reset asserted after the header and 1 data flit → out_valid=0 next cycle, FIFO empty, following packet received correctly.
- NOC_RX_ERR_CNT_EN: 3 error events → err_cnt=3. err_cnt_clr asserted in the same cycle as a 4th error → err_cnt=0.
